// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial pattern scan controller.
package seq_scan_pkg;

    // Controller FSM encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Pattern loaded at reset (MSB is the first bit in time)
    localparam logic [2:0] PAT_RESET = 3'b110;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Handshake and configuration bundle between a byte source/sink and seq_scan_ctrl.
interface seq_scan_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;
    logic              busy;

    modport master (
        output cfg_we, cfg_pattern, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_count, out_hit, busy
    );

    modport slave (
        input  cfg_we, cfg_pattern, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_count, out_hit, busy
    );
endinterface

// File: rtl/seq_det_core.sv
// Overlapping serial sequence detector with a registered (Moore) match output.
// PAT_W must be at least 2.
module seq_det_core #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);
    localparam int SEEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  shift_q, shift_d;
    logic [SEEN_W-1:0] seen_q, seen_d;
    logic              match_q, match_d;

    // Next history, saturating seen-bit count, and match decision for the incoming bit
    always_comb begin
        shift_d = shift_q;
        seen_d  = seen_q;
        match_d = 1'b0;
        if (clear) begin
            shift_d = '0;
            seen_d  = '0;
        end else if (bit_valid) begin
            shift_d = {shift_q[PAT_W-2:0], bit_in};
            if (seen_q < SEEN_W'(PAT_W)) begin
                seen_d = seen_q + SEEN_W'(1);
            end else begin
                seen_d = seen_q;
            end
            match_d = (seen_d == SEEN_W'(PAT_W)) && (shift_d == pattern);
        end else begin
            match_d = 1'b0;
        end
    end

    // History and match registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            seen_q  <= seen_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-level controller: shifts each accepted byte MSB-first into seq_det_core
// and reports the number of matches that completed within that byte.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input logic           clk,
    input logic           reset,
    seq_scan_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_hit_q, out_hit_d;
    logic              busy_q, busy_d;
    logic              cfg_err_q, cfg_err_d;
    logic              core_clear_s;
    logic              bit_valid_s;
    logic              bit_in_s;
    logic              match_s;

    seq_det_core #(.PAT_W(PAT_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (core_clear_s),
        .bit_valid(bit_valid_s),
        .bit_in   (bit_in_s),
        .pattern  (pattern_q),
        .match    (match_s)
    );

    // FSM, byte shifter, bit index, match counter and config handling
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        idx_d        = idx_q;
        count_d      = count_q;
        pattern_d    = pattern_q;
        core_clear_s = 1'b0;
        bit_valid_s  = 1'b0;
        bit_in_s     = 1'b0;
        case (state_q)
            IDLE: begin
                // Config applies before a same-cycle byte so the byte sees the new pattern
                if (bus.cfg_we) begin
                    pattern_d    = bus.cfg_pattern;
                    core_clear_s = 1'b1;
                end else begin
                    pattern_d    = pattern_q;
                end
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // The byte register shifts left so its MSB is always the current bit
                bit_valid_s = 1'b1;
                bit_in_s    = data_q[DATA_W-1];
                data_d      = {data_q[DATA_W-2:0], 1'b0};
                if (match_s) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    count_d = count_q;
                end
                if (idx_q == IDX_W'(DATA_W - 1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                // Collect the registered match produced by the final bit
                if (match_s) begin
                    count_d = count_q + CNT_W'(1);
                end else begin
                    count_d = count_q;
                end
                state_d = REPORT;
            end
            REPORT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cfg_err_d   = bus.cfg_we && (state_q != IDLE);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == REPORT);
        busy_d      = (state_d != IDLE);
        out_hit_d   = (count_d != '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            pattern_q   <= PAT_W'(PAT_RESET);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            pattern_q   <= pattern_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = count_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl.
module tb_seq_scan_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.DATA_W(8), .PAT_W(3), .CNT_W(4)) bus ();

    seq_scan_ctrl #(.DATA_W(8), .PAT_W(3), .CNT_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a byte in IDLE; returns just after the accepting edge.
    task automatic accept(input logic [7:0] b, input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            step();
            n++;
        end
    endtask

    // Full transaction with out_ready held high.
    task automatic run_byte(input logic [7:0] b, input int exp, input string tag);
        int n;
        accept(b, tag);
        wait_valid(n);
        check({tag, "_latency"}, 32'(n), 32'd9);
        check({tag, "_count"}, 32'(bus.out_count), 32'(exp));
        check({tag, "_hit"}, 32'(bus.out_hit), 32'(exp != 0));
        step();
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int seen_valid;
        reset           = 1'b1;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = 3'b000;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.out_ready   = 1'b1;
        step();
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_out_hit", 32'(bus.out_hit), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Pattern 110: 1,1,0,1,1,0,1,1 -> two matches
        run_byte(8'hDB, 2, "db");
        // Boundary 1,1|0 counted in the following byte
        run_byte(8'h00, 1, "zero");

        // Config in IDLE: pattern 111, history cleared, no error
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = 3'b111;
        step();
        bus.cfg_we = 1'b0;
        check("cfg_idle_err", 32'(bus.cfg_err), 32'd0);
        run_byte(8'hFF, 6, "ff1");
        run_byte(8'hFF, 8, "ff2");

        // Back-pressure: history 111 then 0,0,0,0,1,1,1,1 -> 2 matches
        bus.out_ready = 1'b0;
        accept(8'h0F, "hold");
        wait_valid(n);
        check("hold_latency", 32'(n), 32'd9);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_count", 32'(bus.out_count), 32'd2);
            check("hold_hit", 32'(bus.out_hit), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("release_ready", 32'(bus.in_ready), 32'd1);
        check("release_busy", 32'(bus.busy), 32'd0);
        check("release_valid", 32'(bus.out_valid), 32'd0);

        // cfg_we in SHIFT is dropped: 0,1,1,1,0,0,0,0 with 111 -> 1 (000 would give 2)
        accept(8'h70, "cfgshift");
        step();
        step();
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = 3'b000;
        check("cfgshift_err_before", 32'(bus.cfg_err), 32'd0);
        step();
        bus.cfg_we = 1'b0;
        check("cfgshift_err_pulse", 32'(bus.cfg_err), 32'd1);
        step();
        check("cfgshift_err_after", 32'(bus.cfg_err), 32'd0);
        wait_valid(n);
        check("cfgshift_latency", 32'(n), 32'd5);
        check("cfgshift_count", 32'(bus.out_count), 32'd1);
        step();
        check("cfgshift_idle", 32'(bus.in_ready), 32'd1);

        // Reset in the 4th SHIFT cycle drops the byte
        accept(8'hFF, "midrst");
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_count", 32'(bus.out_count), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) seen_valid++;
            step();
        end
        check("midrst_no_report", 32'(seen_valid), 32'd0);
        // Pattern back to 110 with empty history: 0,0,1,1,0,1,1,0 -> 2
        run_byte(8'h36, 2, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
